// File: rtl/tl_pkg.sv
// Shared definitions for the left-turn traffic light controller.
//
// Contents:
//   GREEN/YELLOW/RED/LEFT - 2-bit light codes driven onto La/Lb
//   state_e               - 3-bit binary state encoding S0..S7
//   is_yellow_state       - helper that flags the one-cycle yellow states
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    localparam logic [1:0] LEFT   = 2'b11;

    // S0..S3 serve street A, S4..S7 serve street B.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // A green
        S1 = 3'd1,  // A yellow
        S2 = 3'd2,  // A left arrow
        S3 = 3'd3,  // A yellow
        S4 = 3'd4,  // B green
        S5 = 3'd5,  // B yellow
        S6 = 3'd6,  // B left arrow
        S7 = 3'd7   // B yellow
    } state_e;

    localparam state_e RESET_STATE = S0;

    // Odd states are the single-cycle yellows.
    function automatic logic is_yellow_state(input state_e s);
        return s[0];
    endfunction

endpackage

// File: rtl/tl_state_reg.sv
// State register for the traffic light controller.
//
// Ports:
//   clk_i      - rising-edge clock
//   reset_i    - synchronous active-high reset, loads RESET_STATE (S0)
//   state_d_i  - next state from the transition logic
//   state_q_o  - registered current state
module tl_state_reg
    import tl_pkg::*;
(
    input  logic   clk_i,
    input  logic   reset_i,
    input  state_e state_d_i,
    output state_e state_q_o
);

    state_e state_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d_i;
        end
    end

    assign state_q_o = state_q;

endmodule

// File: rtl/tl_cntr_w_left.sv
// Two-street traffic light controller with left-turn arrows (Moore FSM).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset to S0 (A green, B red)
//   Ta     - through traffic on A, holds A green (S0)
//   Tal    - left-turn traffic on A, holds A arrow (S2)
//   Tb     - through traffic on B, holds B green (S4)
//   Tbl    - left-turn traffic on B, holds B arrow (S6)
//   La     - light on street A (GREEN/YELLOW/RED/LEFT)
//   Lb     - light on street B (GREEN/YELLOW/RED/LEFT)
//
// Lights decode from the state register only, so any input change shows up
// one clock later and there is no combinational input-to-output path.
module tl_cntr_w_left
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    state_e state_q;
    state_e state_d;

    // Next-state logic: each dwell state looks only at its own request line;
    // yellows always advance, so arrows are always entered from a yellow.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = Ta  ? S0 : S1;
            S1:      state_d = S2;
            S2:      state_d = Tal ? S2 : S3;
            S3:      state_d = S4;
            S4:      state_d = Tb  ? S4 : S5;
            S5:      state_d = S6;
            S6:      state_d = Tbl ? S6 : S7;
            S7:      state_d = S0;
            default: state_d = S0;
        endcase
    end

    tl_state_reg u_state_reg (
        .clk_i     (clk),
        .reset_i   (reset),
        .state_d_i (state_d),
        .state_q_o (state_q)
    );

    // Output decode: the street not being served is always RED.
    always_comb begin
        La = RED;
        Lb = RED;
        unique case (state_q)
            S0: begin La = GREEN;  Lb = RED;    end
            S1: begin La = YELLOW; Lb = RED;    end
            S2: begin La = LEFT;   Lb = RED;    end
            S3: begin La = YELLOW; Lb = RED;    end
            S4: begin La = RED;    Lb = GREEN;  end
            S5: begin La = RED;    Lb = YELLOW; end
            S6: begin La = RED;    Lb = LEFT;   end
            S7: begin La = RED;    Lb = YELLOW; end
            default: begin La = RED; Lb = RED;  end
        endcase
    end

endmodule

// File: tb/tb_tl_cntr_w_left.sv
// Self-checking bench for tl_cntr_w_left: a phase-based model checked every
// cycle, plus directed sequences with literal expected lights.
module tb_tl_cntr_w_left;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Ta = 1'b0, Tal = 1'b0, Tb = 1'b0, Tbl = 1'b0;
    logic [1:0] La, Lb;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    tl_cntr_w_left dut (
        .clk   (clk),
        .reset (reset),
        .Ta    (Ta),
        .Tal   (Tal),
        .Tb    (Tb),
        .Tbl   (Tbl),
        .La    (La),
        .Lb    (Lb)
    );

    always #5 clk = ~clk;

    // Full rotation (La,Lb) with all requests idle, starting at A green.
    logic [1:0] rot_la [8] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [1:0] rot_lb [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};

    // Model: position in the 8-step rotation; a phase waits while its
    // request line is high, every other phase moves on after one cycle.
    int  phase = 0;
    bit  model_valid = 1'b0;

    function automatic bit phase_held(int p, logic a, logic al, logic b, logic bl);
        case (p)
            0: return a;
            2: return al;
            4: return b;
            6: return bl;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            phase <= 0;
            model_valid <= 1'b1;
        end else if (!phase_held(phase, Ta, Tal, Tb, Tbl)) begin
            phase <= (phase + 1) % 8;
        end
    end

    task automatic check(input string name, input logic [1:0] exp_la,
                         input logic [1:0] exp_lb);
        n_total++;
        if (La === exp_la && Lb === exp_lb) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got La=%b Lb=%b, expected La=%b Lb=%b",
                     name, La, Lb, exp_la, exp_lb);
        end
    endtask

    // Per-cycle comparison against the model, plus the never-both-non-red rule.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model", rot_la[phase], rot_lb[phase]);
            n_total++;
            if (La == 2'b10 || Lb == 2'b10) n_pass++;
            else $display("FAIL conflict: got La=%b Lb=%b, required one RED", La, Lb);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset hold while poking each request individually.
        step(1);
        for (int i = 0; i < 5; i++) begin
            Ta  = (i == 0);
            Tal = (i == 1);
            Tb  = (i == 2);
            Tbl = (i == 3);
            step(1);
            check("rst_hold", 2'b00, 2'b10);
        end
        Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
        reset = 0;

        // Two full idle rotations.
        for (int k = 0; k < 16; k++) begin
            step(1);
            check("rotation", rot_la[(k + 1) % 8], rot_lb[(k + 1) % 8]);
        end

        // A green dwell, then release.
        Ta = 1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("dwell_a", 2'b00, 2'b10);
        end
        Ta = 0;
        step(1); check("a_to_yellow", 2'b01, 2'b10);
        step(1); check("a_to_left", 2'b11, 2'b10);

        // A arrow dwell.
        Tal = 1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("dwell_al", 2'b11, 2'b10);
        end
        Tal = 0;
        step(1); check("al_to_yellow", 2'b01, 2'b10);
        step(1); check("b_green", 2'b10, 2'b00);

        // B green dwell.
        Tb = 1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("dwell_b", 2'b10, 2'b00);
        end
        Tb = 0;
        step(1); check("b_to_yellow", 2'b10, 2'b01);
        step(1); check("b_to_left", 2'b10, 2'b11);

        // B arrow dwell.
        Tbl = 1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("dwell_bl", 2'b10, 2'b11);
        end
        Tbl = 0;
        step(1); check("bl_to_yellow", 2'b10, 2'b01);
        step(1); check("wrap_a_green", 2'b00, 2'b10);

        // Only Tb high from S0: rotation runs until B green, which then holds.
        Tb = 1;
        step(1); check("irr_s1", 2'b01, 2'b10);
        step(1); check("irr_s2", 2'b11, 2'b10);
        step(1); check("irr_s3", 2'b01, 2'b10);
        step(1); check("irr_s4", 2'b10, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("irr_hold", 2'b10, 2'b00);
        end
        Tb = 0;

        // Yellow ignores every request at once.
        step(1); check("s5", 2'b10, 2'b01);
        Ta = 1; Tal = 1; Tb = 1; Tbl = 1;
        step(1); check("yellow_one_cycle", 2'b10, 2'b11);

        // Reset in the B arrow state.
        reset = 1;
        step(1); check("rst_mid", 2'b00, 2'b10);
        reset = 0; Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
        step(1); check("after_rst", 2'b01, 2'b10);

        // Reset in a yellow state.
        reset = 1;
        step(1); check("rst_yellow", 2'b00, 2'b10);
        reset = 0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tl_cntr_w_left.md
TL_CNTR_W_LEFT -- requirements
Module: tl_cntr_w_left

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose these ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- Ta  input  1  traffic present on street A (through)
- Tal  input  1  traffic waiting to turn left from A
- Tb  input  1  traffic present on street B (through)
- Tbl  input  1  traffic waiting to turn left from B
- La  output  2  light on street A
- Lb  output  2  light on street B
REQ-003 The light encoding SHALL be:
- GREEN = 2'b00
- YELLOW = 2'b01
- RED = 2'b10
- LEFT = 2'b11 (left-turn arrow)

Function
REQ-004 The block SHALL be a Moore FSM with eight states S0..S7, 3-bit binary encoded 0..7; La and Lb SHALL depend only on the state register.
REQ-005 State outputs (La/Lb) SHALL be:
- S0 G/R
- S1 Y/R
- S2 LEFT/R
- S3 Y/R
- S4 R/G
- S5 R/Y
- S6 R/LEFT
- S7 R/Y
REQ-006 Transitions, evaluated on each rising clk edge:
- S0: stay if Ta=1, else S1
- S1: always S2
- S2: stay if Tal=1, else S3
- S3: always S4
- S4: stay if Tb=1, else S5
- S5: always S6
- S6: stay if Tbl=1, else S7
- S7: always S0
REQ-007 Yellow states (S1, S3, S5, S7) SHALL last exactly one clock cycle regardless of inputs.
REQ-008 Only the input relevant to the current state SHALL affect the transition; all other inputs are ignored, including when several are asserted simultaneously.
REQ-009 Input-to-output latency SHALL be one clock: an input change sampled at edge k changes La/Lb immediately after edge k, with no combinational input-to-output path.
REQ-010 A LEFT state (S2/S6) SHALL always be entered directly from a one-cycle yellow and SHALL be visited once per full cycle even when its left input is 0 (minimum one cycle).
REQ-011 Unused or illegal state values SHALL be impossible with 3-bit encoding; the default branch of next-state logic SHALL go to S0.
REQ-012 The two streets SHALL never both show non-RED in any state.

Reset
REQ-013 When reset=1 at a rising clk edge, the state SHALL become S0 (La=GREEN, Lb=RED) on that edge.
REQ-014 Reset SHALL override all transitions and SHALL hold S0 while asserted, regardless of Ta/Tal/Tb/Tbl.
REQ-015 Reset asserted mid-cycle (any state, including yellow or LEFT) SHALL return to S0 at the next edge.
REQ-016 Before the first reset edge, outputs are undefined and SHALL NOT be checked.

Structure
REQ-017 A shared package (tl_pkg) SHALL hold:
- the light-code constants GREEN/YELLOW/RED/LEFT
- the state constants S0..S7
REQ-018 The design SHALL be partitioned into three parts:
- next-state combinational logic
- the state register (a sub-module tl_state_reg: 3-bit flip-flop with synchronous active-high reset to S0)
- output decode logic

Verification
REQ-019 Reset hold: reset=1 for 5 cycles while toggling Ta, Tal, Tb, Tbl individually -> La=00, Lb=10 throughout.
REQ-020 Full rotation with all inputs 0 after reset release -> output sequence repeats every 8 cycles:
- (La,Lb) = (00,10), (01,10), (11,10), (01,10), (10,00), (10,01), (10,11), (10,01)
REQ-021 Dwell: Ta=1 held 10 cycles -> stays S0 (00/10); drop Ta -> next edge 01/10, then 11/10.
REQ-022 Left dwell: Tal=1 while in S2 -> La=11 held until Tal=0, then one cycle of 01 then La=10/Lb=00; the same check SHALL be repeated with Tbl in S6 (Lb=11) and Tb in S4 (Lb=00).
REQ-023 Irrelevant input: Tb=1 only, starting in S0 -> S0 not held, sequence advances to S4, which holds while Tb=1.
REQ-024 Reset mid-operation: assert reset in S6 -> next edge La=00, Lb=10.
